// File: rtl/pipe_scroller.sv
// Three scrolling pipe obstacles: frame-tick divider, per-tick leftward motion,
// LFSR-driven gap recycling and a one-cycle pass pulse when a pipe clears the bird.
module pipe_scroller #(
   parameter int unsigned TICK_DIV     = 1_000_000,
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned PIPE_W       = 52,
   parameter int unsigned PIPE_SPACING = 240,
   parameter int unsigned GAP_MIN      = 80,
   parameter int unsigned GAP_RANGE    = 256,
   parameter int unsigned BIRD_X       = 160,
   parameter int unsigned SPEED_SLOW   = 2,
   parameter int unsigned SPEED_FAST   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        restart,
   input  logic        mode,
   output logic [31:0] pipe_1,
   output logic [31:0] pipe_2,
   output logic [31:0] pipe_3,
   output logic        frame_tick,
   output logic        pass
);

   localparam int unsigned     CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned     NPIPE     = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [15:0]     LFSR_SEED = 16'hACE1;
   localparam logic [15:0]     LFSR_MASK = 16'hB400;
   localparam logic signed [15:0] PW_S   = 16'(PIPE_W);
   localparam logic signed [15:0] NEG_PW = -PW_S;
   localparam logic signed [15:0] BIRD_S = 16'(BIRD_X);
   localparam logic signed [15:0] WRAP_S = 16'(3 * PIPE_SPACING);
   localparam logic [15:0]     GAP_RST   = 16'(GAP_MIN + 64);
   localparam logic [15:0]     GAP_BASE  = 16'(GAP_MIN);
   localparam logic [15:0]     GAP_MASK  = 16'(GAP_RANGE - 1);

   function automatic logic signed [15:0] start_x(input int unsigned k);
      return 16'(SCREEN_W + k * PIPE_SPACING);
   endfunction

   logic [CNT_W-1:0]   r_cnt;
   logic               r_frame_tick;
   logic               r_pass;
   logic [15:0]        r_lfsr;
   logic signed [15:0] r_x   [NPIPE];
   logic [15:0]        r_gap [NPIPE];

   logic signed [15:0] w_speed;
   logic               w_move;
   logic [15:0]        w_lfsr_nxt;
   logic [NPIPE-1:0]   w_cross;

   // Shared per-tick controls and the Galois LFSR step
   always_comb begin
      w_speed    = mode ? 16'(SPEED_FAST) : 16'(SPEED_SLOW);
      w_move     = r_frame_tick & run & ~restart;
      w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
   end

   // Tick divider, LFSR and pass pulse; counter and LFSR ignore restart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_frame_tick <= 1'b0;
         r_lfsr       <= LFSR_SEED;
         r_pass       <= 1'b0;
      end else begin
         r_cnt        <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
         r_frame_tick <= (r_cnt == CNT_LAST);
         r_lfsr       <= w_lfsr_nxt;
         r_pass       <= |w_cross;
      end
   end

   for (genvar g = 0; g < NPIPE; g++) begin : g_pipe
      logic signed [15:0] w_xm;
      logic               w_recycle;
      logic signed [15:0] w_x_nxt;
      logic [15:0]        w_gap_nxt;

      // Next position; a recycled pipe jumps one full period right and never scores
      always_comb begin
         w_xm      = r_x[g] - w_speed;
         w_recycle = (w_xm <= NEG_PW);
         w_x_nxt   = r_x[g];
         w_gap_nxt = r_gap[g];
         w_cross[g] = 1'b0;
         if (restart) begin
            w_x_nxt   = start_x(g);
            w_gap_nxt = GAP_RST;
         end else if (w_move) begin
            if (w_recycle) begin
               w_x_nxt   = w_xm + WRAP_S;
               w_gap_nxt = GAP_BASE + (r_lfsr & GAP_MASK);
            end else begin
               w_x_nxt    = w_xm;
               w_cross[g] = (r_x[g] + PW_S >= BIRD_S) && (w_xm + PW_S < BIRD_S);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_x[g]   <= start_x(g);
            r_gap[g] <= GAP_RST;
         end else begin
            r_x[g]   <= w_x_nxt;
            r_gap[g] <= w_gap_nxt;
         end
      end
   end

   assign pipe_1     = {r_x[0], r_gap[0]};
   assign pipe_2     = {r_x[1], r_gap[1]};
   assign pipe_3     = {r_x[2], r_gap[2]};
   assign frame_tick = r_frame_tick;
   assign pass       = r_pass;

endmodule
